// File: rtl/i2c_reg_bridge_burst.sv
// I2C-slave byte stream to register-bus bridge: configurable address/data width,
// burst auto-increment, current-address reads, read-data timeout and error pulse.
module i2c_reg_bridge_burst #(
  parameter int unsigned ADDR_BYTES = 2,
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned AUTO_INC   = 1,
  parameter int unsigned ADDR_STEP  = 4,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    tx_req,
  output logic [7:0]              tx_data,
  input  logic                    sr_start,
  input  logic                    inframe,
  input  logic                    addr_match,
  input  logic                    rw_bit,
  output logic [8*ADDR_BYTES-1:0] addr,
  output logic                    wr_en,
  output logic                    rd_en,
  output logic [8*DATA_BYTES-1:0] wdata,
  input  logic [8*DATA_BYTES-1:0] rdata,
  input  logic                    rd_valid,
  output logic                    err
);
  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [2:0]    ALAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0]    DLAST = 3'(DATA_BYTES - 1);
  localparam logic [TW-1:0] TLAST = TW'(RD_TIMEOUT - 1);
  localparam logic [AW-1:0] INC   = (AUTO_INC != 0) ? AW'(ADDR_STEP) : '0;

  typedef enum logic [2:0] {
    IDLE, DEV, ADDR, WDATA, WCMD, RREQ, RWAIT, RDATA
  } state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] rbuf;
  logic          sr_pend;
  logic          word_done;

  assign word_done = rx_valid && (cnt == DLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tcnt    <= '0;
      rbuf    <= '0;
      sr_pend <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      err     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      err   <= 1'b0;
      if (!inframe) begin
        state   <= IDLE;
        sr_pend <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= DEV;
          DEV: if (addr_match) begin
            cnt <= '0;
            if (rw_bit) begin
              state <= RREQ;
              rd_en <= 1'b1;
            end else begin
              state <= ADDR;
            end
          end
          ADDR: if (rx_valid) begin
            addr <= (addr << 8) | AW'(rx_data);
            if (cnt == ALAST) begin
              cnt   <= '0;
              state <= WDATA;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          WDATA: begin
            if (rx_valid) begin
              wdata <= (wdata << 8) | DW'(rx_data);
              cnt   <= cnt + 3'd1;
            end
            // A completing byte wins over sr_start; the restart is replayed after WCMD.
            if (word_done) begin
              state   <= WCMD;
              wr_en   <= 1'b1;
              sr_pend <= sr_start;
            end else if (sr_start) begin
              state <= DEV;
              err   <= rx_valid || (cnt != 3'd0);
            end
          end
          WCMD: begin
            addr    <= addr + INC;
            cnt     <= '0;
            sr_pend <= 1'b0;
            state   <= (sr_pend || sr_start) ? DEV : WDATA;
          end
          RREQ: begin
            tcnt  <= '0;
            state <= RWAIT;
          end
          RWAIT: begin
            if (rd_valid) begin
              rbuf  <= rdata;
              cnt   <= '0;
              state <= RDATA;
            end else if (tcnt == TLAST) begin
              rbuf  <= '1;
              err   <= 1'b1;
              cnt   <= '0;
              state <= RDATA;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          RDATA: if (tx_req) begin
            // Buffer shifts up so the byte being offered is always the top one.
            rbuf <= rbuf << 8;
            if (cnt == DLAST) begin
              addr  <= addr + INC;
              state <= RREQ;
              rd_en <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    tx_data = '0;
    if (state == RWAIT) tx_data = 8'hFF;
    else if (state == RDATA) tx_data = rbuf[DW-1 -: 8];
  end
endmodule

// File: tb/tb_i2c_reg_bridge_burst.sv
// Directed-plus-random bench: acts as I2C byte engine and register-bus slave,
// predicting bus transactions from a simple address/memory model.
module tb_i2c_reg_bridge_burst;
  localparam int unsigned RDT = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_req = 1'b0;
  logic [7:0]  tx_data;
  logic        sr_start = 1'b0;
  logic        inframe = 1'b0;
  logic        addr_match = 1'b0;
  logic        rw_bit = 1'b0;
  logic [15:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        err;

  i2c_reg_bridge_burst #(
    .ADDR_BYTES(2), .DATA_BYTES(4), .AUTO_INC(1), .ADDR_STEP(4), .RD_TIMEOUT(RDT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_req(tx_req), .tx_data(tx_data), .sr_start(sr_start), .inframe(inframe),
    .addr_match(addr_match), .rw_bit(rw_bit), .addr(addr), .wr_en(wr_en),
    .rd_en(rd_en), .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0, rd_cyc = 0, err_cyc = 0, err_cnt = 0, overlap = 0;
  int rd_delay = 2;
  logic [15:0] m_addr = '0;
  logic [15:0] exp_wa[$], obs_wa[$], exp_ra[$], obs_ra[$];
  logic [31:0] exp_wd[$], obs_wd[$];
  logic [31:0] mem[int unsigned];

  function automatic logic [31:0] get_word(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en) begin obs_wa.push_back(addr); obs_wd.push_back(wdata); end
    if (rd_en) begin obs_ra.push_back(addr); rd_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (wr_en && rd_en) overlap++;
  end

  // Register-bus slave: answers rd_en after rd_delay cycles (negative = never).
  initial begin
    logic [15:0] a;
    int d;
    rd_valid = 1'b0;
    rdata = '0;
    forever begin
      @(negedge clk);
      if (rd_en === 1'b1 && rd_delay >= 0) begin
        a = addr;
        d = rd_delay;
        repeat (d) @(negedge clk);
        rdata = get_word(a);
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; tick();
    rx_valid = 1'b0; tick();
  endtask

  task automatic dev(input logic rw);
    addr_match = 1'b1; rw_bit = rw; tick();
    addr_match = 1'b0; tick();
    if (rw) exp_ra.push_back(m_addr);
  endtask

  task automatic start_frame();
    inframe = 1'b1; tick();
  endtask

  task automatic end_frame();
    inframe = 1'b0;
    repeat (4) tick();
  endtask

  task automatic sr();
    sr_start = 1'b1; tick();
    sr_start = 1'b0; tick();
  endtask

  task automatic begin_write(input logic [15:0] a);
    start_frame();
    dev(1'b0);
    rx_byte(a[15:8]);
    rx_byte(a[7:0]);
    m_addr = a;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) rx_byte(w[31-8*k -: 8]);
    tick();
    exp_wa.push_back(m_addr);
    exp_wd.push_back(w);
    m_addr = m_addr + 16'd4;
  endtask

  task automatic read_word(input string tag, input logic [31:0] w, input int wait_cyc);
    repeat (wait_cyc) tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_b%0d", tag, k), tx_data, w[31-8*k -: 8]);
      tx_req = 1'b1; tick();
      tx_req = 1'b0; tick();
    end
    m_addr = m_addr + 16'd4;
    exp_ra.push_back(m_addr);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wcount"}, obs_wa.size(), exp_wa.size());
    while (exp_wa.size() > 0 && obs_wa.size() > 0) begin
      chk({tag, "_waddr"}, obs_wa.pop_front(), exp_wa.pop_front());
      chk({tag, "_wdata"}, obs_wd.pop_front(), exp_wd.pop_front());
    end
    exp_wa.delete(); exp_wd.delete(); obs_wa.delete(); obs_wd.delete();
  endtask

  task automatic check_reads(input string tag);
    chk({tag, "_rcount"}, obs_ra.size(), exp_ra.size());
    while (exp_ra.size() > 0 && obs_ra.size() > 0)
      chk({tag, "_raddr"}, obs_ra.pop_front(), exp_ra.pop_front());
    exp_ra.delete(); obs_ra.delete();
  endtask

  initial begin
    int e0;
    int n;
    logic [31:0] w;
    logic [15:0] a;

    repeat (3) tick();
    chk("rst_addr", addr, 16'h0000);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_tx", tx_data, 8'h00);
    chk("rst_pulses", {wr_en, rd_en, err}, 3'b000);
    rst_n = 1'b1;
    tick();

    // Single write
    begin_write(16'h0010);
    send_word(32'hDEADBEEF);
    end_frame();
    check_writes("wr1");
    chk("wr1_addr_inc", addr, m_addr);

    // Burst write of two words
    begin_write(16'h0010);
    send_word($urandom);
    send_word($urandom);
    end_frame();
    check_writes("burst");
    chk("burst_addr", addr, 16'h0018);

    // Random read at 0x0020 after repeated start, then prefetched next word
    e0 = err_cnt;
    begin_write(16'h0020);
    sr();
    mem[16'h0020] = 32'h11223344;
    rd_delay = 3;
    dev(1'b1);
    read_word("rd20", 32'h11223344, rd_delay + 3);
    read_word("rd24", get_word(m_addr), rd_delay + 3);
    end_frame();
    chk("rd_no_err", err_cnt - e0, 0);

    // Current-address read that times out
    rd_delay = -1;
    e0 = err_cnt;
    start_frame();
    dev(1'b1);
    repeat (10) tick();
    chk("rwait_tx_ff", tx_data, 8'hFF);
    for (int i = 0; i < 400 && err_cnt == e0; i++) tick();
    chk("to_err_count", err_cnt - e0, 1);
    chk("to_latency", err_cyc - rd_cyc, RDT + 1);
    read_word("to", 32'hFFFFFFFF, 1);
    end_frame();
    check_reads("rdseq");
    chk("to_addr", addr, 16'h002C);

    // Partial word dropped by end of frame
    e0 = err_cnt;
    begin_write(16'h0040);
    rx_byte($urandom);
    rx_byte($urandom);
    end_frame();
    check_writes("partial");
    chk("partial_addr", addr, 16'h0040);
    chk("partial_no_err", err_cnt - e0, 0);

    // Partial word dropped by repeated start -> err
    e0 = err_cnt;
    begin_write(16'h0050);
    rx_byte($urandom);
    sr();
    chk("sr_partial_err", err_cnt - e0, 1);
    end_frame();
    check_writes("sr_partial");

    // Address wrap then current-address read at 0x0000
    begin_write(16'hFFFC);
    send_word($urandom);
    end_frame();
    check_writes("wrap");
    chk("wrap_addr", addr, 16'h0000);
    rd_delay = $urandom_range(1, 5);
    start_frame();
    dev(1'b1);
    read_word("wrap_rd", get_word(m_addr), rd_delay + 3);
    end_frame();
    check_reads("wrap_rd");

    // Completing byte coincides with sr_start: write still issued, then new DEV phase
    e0 = err_cnt;
    begin_write(16'h0060);
    w = $urandom;
    for (int k = 0; k < 3; k++) rx_byte(w[31-8*k -: 8]);
    rx_data = w[7:0]; rx_valid = 1'b1; sr_start = 1'b1; tick();
    rx_valid = 1'b0; sr_start = 1'b0; tick(); tick();
    exp_wa.push_back(m_addr); exp_wd.push_back(w); m_addr = m_addr + 16'd4;
    rd_delay = $urandom_range(1, 5);
    dev(1'b1);
    read_word("simul_rd", get_word(m_addr), rd_delay + 3);
    end_frame();
    check_writes("simul");
    check_reads("simul");
    chk("simul_no_err", err_cnt - e0, 0);

    // Randomized bursts followed by current-address reads
    for (int it = 0; it < 4; it++) begin
      a = 16'($urandom);
      n = $urandom_range(1, 3);
      begin_write(a);
      for (int j = 0; j < n; j++) send_word($urandom);
      end_frame();
      check_writes($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_addr", it), addr, m_addr);
      rd_delay = $urandom_range(1, 6);
      start_frame();
      dev(1'b1);
      read_word($sformatf("rnd%0d_rd", it), get_word(m_addr), rd_delay + 3);
      end_frame();
      check_reads($sformatf("rnd%0d", it));
    end

    // Reset in the middle of a read wait
    rd_delay = -1;
    start_frame();
    dev(1'b1);
    repeat (5) tick();
    check_reads("pre_rst");
    rst_n = 1'b0;
    tick();
    chk("midrst_addr", addr, 16'h0000);
    chk("midrst_tx", tx_data, 8'h00);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("midrst_no_rd", obs_ra.size(), 0);
    chk("midrst_no_wr", obs_wa.size(), 0);
    inframe = 1'b0;
    tick();

    chk("no_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_reg_bridge_burst.md
Name: i2c_reg_bridge_burst

Overview:
Parametrised I2C-slave-to-register-bus bridge. Sits between the I2C byte engine (rx/tx byte strobes, frame and start flags) and the on-chip register bus. Extends the single-word bridge with configurable address and data widths, burst auto-increment, current-address reads, a read-data handshake with timeout, and error reporting.

Parameters:
ADDR_BYTES, 2, register address bytes received after device address (1..4)
DATA_BYTES, 4, bytes per register word (1..4)
AUTO_INC, 1, 1 = advance address after every completed word; 0 = address held
ADDR_STEP, 4, increment applied to addr per completed word
RD_TIMEOUT, 255, clk cycles to wait for rd_valid before substituting 0xFF bytes

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid with rx_valid
rx_valid  in  1  one-cycle strobe, byte received (write direction)
tx_req  in  1  one-cycle strobe, master consumed tx_data (read direction)
tx_data  out  8  byte presented to the I2C engine
sr_start  in  1  repeated START detected
inframe  in  1  high between START and STOP
addr_match  in  1  one-cycle strobe, device address matched
rw_bit  in  1  R/W bit of matched device address, valid with addr_match
addr  out  8*ADDR_BYTES  register bus address
wr_en  out  1  one-cycle write pulse
rd_en  out  1  one-cycle read request pulse
wdata  out  8*DATA_BYTES  write data, valid with wr_en
rdata  in  8*DATA_BYTES  read data, sampled when rd_valid
rd_valid  in  1  read data valid (any cycle ≥1 after rd_en)
err  out  1  one-cycle pulse: partial word dropped or read timeout

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. State IDLE; addr, wdata, tx_data, byte count, read buffer = 0; wr_en, rd_en, err = 0.
- Byte order is MSB first for both address and data. The first received byte fills the top byte.
- Priority: inframe=0 forces IDLE next cycle from any state. This overrides all other events. Addr is retained across frames so current-address reads work.
- States: IDLE, DEV, ADDR, WDATA, WCMD, RREQ, RWAIT, RDATA.
- IDLE -> DEV on inframe=1.
- DEV, on addr_match:
  - rw_bit=0 -> ADDR; byte count cleared.
  - rw_bit=1 -> RREQ. This is a current-address read using the held addr.
- ADDR: each rx_valid shifts rx_data into addr and increments count. On the ADDR_BYTES-th byte -> WDATA with count cleared.
- WDATA:
  - Each rx_valid shifts rx_data into wdata.
  - On the DATA_BYTES-th byte -> WCMD.
  - sr_start -> DEV. If 0 < count < DATA_BYTES, the partial word is dropped and err pulses.
- WCMD: wr_en=1 for exactly one cycle with the stable addr/wdata. Next cycle, addr += ADDR_STEP if AUTO_INC=1, then -> WDATA with count cleared.
- RREQ: rd_en=1 for one cycle -> RWAIT. Timeout counter cleared.
- RWAIT:
  - rd_valid latches rdata into the read buffer -> RDATA with count cleared.
  - rd_valid may coincide with the cycle after rd_en.
  - If RD_TIMEOUT cycles elapse: buffer loaded with all 0xFF, err pulses -> RDATA.
  - tx_data = 0xFF while in RWAIT.
- RDATA:
  - tx_data = buffer byte[count], combinational, MSB first.
  - Each tx_req increments count.
  - After the DATA_BYTES-th tx_req: addr += ADDR_STEP if AUTO_INC -> RREQ, prefetching the next word.
- Address arithmetic wraps modulo 2^(8*ADDR_BYTES). No saturation.
- Simultaneous rx_valid and sr_start in WDATA: the byte is taken first, then sr_start is evaluated on the same cycle. A byte that completes the word still goes to WCMD; the repeated start is then handled as a new DEV phase after WCMD.
- wr_en and rd_en are never asserted in the same cycle. Neither is asserted outside WCMD/RREQ.
- An inframe drop during RWAIT abandons the read. A later rd_valid is ignored. addr is not incremented.
- Reset mid-operation: all state returns to reset values immediately. There is no pending write or read pulse afterwards.

Test Plan:
- Write: addr_match rw=0, rx 0x00 0x10 0xDE 0xAD 0xBE 0xEF -> one wr_en, addr=0x0010, wdata=0xDEADBEEF.
- Burst write of 8 data bytes from 0x0010 with AUTO_INC=1 -> wr_en at addr 0x0010, then at 0x0014.
- Random read: rx 0x00 0x20, sr_start, addr_match rw=1; rd_valid 3 cycles after rd_en with rdata=0x11223344.
  - tx_data = 0x11, 0x22, 0x33, 0x44 across tx_req.
  - A second rd_en follows at addr 0x0024.
- Current-address read in a new frame after the test above: rw=1 -> rd_en at addr 0x0028.
- Timeout: rd_valid never asserted -> err pulses after 255 cycles; tx_data=0xFF for all 4 bytes.
- Partial word: 2 data bytes, then inframe=0 -> no wr_en, state IDLE, addr unchanged; a later wrap check from 0xFFFC increments to 0x0000.
